// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and write-back
// states and drives every datapath mux select and enable from the current state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (forces FETCH)
//   opcode     instruction register bits [31:26], sampled in DECODE
//   zero       ALU zero flag, only meaningful in BEQ
//   pc_en      PC load enable = pc_write | (branch & zero)
//   iord       memory address select: 0 = PC, 1 = ALUOut
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//   ir_write   instruction register load
//   mem_to_reg register write data: 1 = MDR, 0 = ALUOut
//   reg_dst    destination register: 1 = rd, 0 = rt
//   reg_write  register file write enable
//   alu_src_a  ALU A: 0 = PC, 1 = register A
//   alu_src_b  ALU B: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op     ALU control: 00 add, 01 sub, 10 funct
//   pc_source  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump address
//   illegal    one-cycle pulse in the FETCH after an unsupported opcode
//   state      current state encoding, for debug display
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBeq    = 4'd8,
    StAddi   = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  state_e state_q;
  logic   illegal_q;
  logic   pc_write;
  logic   branch;

  // State register and the registered illegal flag in one block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StExec;
            OpBeq:      state_q <= StBeq;
            OpAddi:     state_q <= StAddi;
            OpJ:        state_q <= StJump;
            default: begin
              state_q   <= StFetch;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // IR is only loaded in FETCH, so opcode is still lw or sw here.
        StMemAdr: state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd:  state_q <= StMemWb;
        StExec:   state_q <= StAluWb;
        StAddi:   state_q <= StAddiWb;
        default:  state_q <= StFetch;  // write-backs, BEQ, JUMP, unused codes
      endcase
    end
  end

  // Moore output decode; anything not set for a state stays 0.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBeq: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        branch    = 1'b1;
      end
      StAddi: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign pc_en   = pc_write | (branch & zero);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .pc_en     (pc_en),
    .iord      (iord),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .mem_to_reg(mem_to_reg),
    .reg_dst   (reg_dst),
    .reg_write (reg_write),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_source (pc_source),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample mid-cycle on the falling edge.
  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 6'b100011;  // lw
    zero   = 1'b0;
    step();
    step();
    // Reset: FETCH strobes visible
    check_eq("rst_state", state, 0);
    check_eq("rst_mem_read", mem_read, 1);
    check_eq("rst_ir_write", ir_write, 1);
    check_eq("rst_pc_en", pc_en, 1);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_illegal", illegal, 0);
    rst = 1'b0;

    // lw: 0,1,2,3,4,0
    step(); check_eq("lw_s1", state, 1);
    check_eq("lw_dec_alu_src_b", alu_src_b, 3);
    step(); check_eq("lw_s2", state, 2);
    check_eq("lw_memadr_reg_write", reg_write, 0);
    step(); check_eq("lw_s3", state, 3);
    check_eq("lw_memrd_iord", iord, 1);
    check_eq("lw_memrd_mem_to_reg", mem_to_reg, 0);
    step(); check_eq("lw_s4", state, 4);
    check_eq("lw_memwb_mem_to_reg", mem_to_reg, 1);
    check_eq("lw_memwb_reg_write", reg_write, 1);
    step(); check_eq("lw_s0", state, 0);
    check_eq("lw_fetch_reg_write", reg_write, 0);

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    step(); check_eq("r_s1", state, 1);
    step(); check_eq("r_s6", state, 6);
    check_eq("r_exec_alu_op", alu_op, 2);
    check_eq("r_exec_alu_src_a", alu_src_a, 1);
    step(); check_eq("r_s7", state, 7);
    check_eq("r_aluwb_reg_dst", reg_dst, 1);
    check_eq("r_aluwb_reg_write", reg_write, 1);
    step(); check_eq("r_s0", state, 0);

    // addi: 0,1,9,10,0
    opcode = 6'b001000;
    step(); check_eq("addi_s1", state, 1);
    step(); check_eq("addi_s9", state, 9);
    check_eq("addi_alu_src_b", alu_src_b, 2);
    step(); check_eq("addi_s10", state, 10);
    check_eq("addi_reg_dst", reg_dst, 0);
    check_eq("addi_reg_write", reg_write, 1);
    check_eq("addi_mem_to_reg", mem_to_reg, 0);
    step(); check_eq("addi_s0", state, 0);

    // beq taken: zero outside BEQ must not load PC
    opcode = 6'b000100;
    zero   = 1'b1;
    step(); check_eq("beq_s1", state, 1);
    check_eq("beq_dec_pc_en", pc_en, 0);
    step(); check_eq("beq_s8", state, 8);
    check_eq("beq_t_pc_en", pc_en, 1);
    check_eq("beq_t_pc_source", pc_source, 1);
    check_eq("beq_t_alu_op", alu_op, 1);
    zero = 1'b0;
    #1 check_eq("beq_zero_follow", pc_en, 0);
    step(); check_eq("beq_t_s0", state, 0);

    // beq not taken
    step(); check_eq("beq_nt_s1", state, 1);
    step(); check_eq("beq_nt_s8", state, 8);
    check_eq("beq_nt_pc_en", pc_en, 0);
    step(); check_eq("beq_nt_s0", state, 0);

    // sw: 0,1,2,5,0
    opcode = 6'b101011;
    step(); check_eq("sw_s1", state, 1);
    check_eq("sw_dec_reg_write", reg_write, 0);
    step(); check_eq("sw_s2", state, 2);
    check_eq("sw_memadr_mem_write", mem_write, 0);
    step(); check_eq("sw_s5", state, 5);
    check_eq("sw_mem_write", mem_write, 1);
    check_eq("sw_iord", iord, 1);
    check_eq("sw_reg_write", reg_write, 0);
    step(); check_eq("sw_s0", state, 0);
    check_eq("sw_fetch_mem_write", mem_write, 0);

    // j: 0,1,11,0
    opcode = 6'b000010;
    step(); check_eq("j_s1", state, 1);
    step(); check_eq("j_s11", state, 11);
    check_eq("j_pc_en", pc_en, 1);
    check_eq("j_pc_source", pc_source, 2);
    step(); check_eq("j_s0", state, 0);
    check_eq("j_fetch_illegal", illegal, 0);

    // Unsupported opcode: 0,1,0 with illegal only in the second FETCH
    opcode = 6'b111111;
    step(); check_eq("ill_s1", state, 1);
    check_eq("ill_dec_illegal", illegal, 0);
    step(); check_eq("ill_s0", state, 0);
    check_eq("ill_fetch_illegal", illegal, 1);
    opcode = 6'b101011;
    step(); check_eq("ill_next_s1", state, 1);
    check_eq("ill_pulse_end", illegal, 0);

    // Reset during MEMWR drops mem_write before the next edge
    step(); check_eq("rst_sw_s2", state, 2);
    step(); check_eq("rst_sw_s5", state, 5);
    check_eq("rst_sw_mem_write", mem_write, 1);
    #2 rst = 1'b1;
    #1 check_eq("async_mem_write", mem_write, 0);
    check_eq("async_state", state, 0);
    check_eq("async_iord", iord, 0);
    step();
    rst = 1'b0;
    step(); check_eq("post_rst_s1", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
